stack_ctrl: RTL
===============

# stack_ctrl

Sequencing controller that turns the 1024×8 single-port RAM into a pushdown stack (LIFO) for the PushdownStack design. It owns the stack pointer and drives RAM address, data-in, chip select and read/write select. Every RAM access runs as a setup/strobe/hold sequence, so address and data are stable whenever CS is high. It presents a request/acknowledge push/pop interface with full/empty, occupancy and sticky error flags.

## Interface
- AW, 10, RAM address width; stack depth is 2^AW.
- DW, 8, data width.
- CLK  in  1  single clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- PUSH  in  1  push request; held until ACK.
- POP  in  1  pop request; held until ACK.
- CLR  in  1  synchronous stack clear (empties the stack, aborts the current access).
- DIN  in  DW  push data; sampled on the accept edge.
- DOUT  out  DW  popped data; registered, holds its last value.
- VALID  out  1  one-cycle pulse: DOUT was just updated by a pop.
- ACK  out  1  one-cycle pulse: request accepted.
- BUSY  out  1  FSM not in IDLE.
- FULL  out  1  COUNT == 2^AW.
- EMPTY  out  1  COUNT == 0.
- COUNT  out  AW+1  current occupancy, 0..2^AW.
- OVF  out  1  sticky: push requested while FULL.
- UNF  out  1  sticky: pop requested while EMPTY.
- RAM_ADDR  out  AW  to RAM ADDR.
- RAM_DI  out  DW  to RAM I.
- RAM_DO  in  DW  from RAM O.
- RAM_CS  out  1  to RAM CS.
- RAM_RWS  out  1  to RAM RWS (1 = write, 0 = read).

## Operation
- States: IDLE, W_SETUP, W_STROBE, W_HOLD, R_SETUP, R_STROBE.
- Accept rule: requests are accepted only in IDLE with CLR low.
  - Pop: POP=1 and EMPTY=0.
  - Push: PUSH=1, FULL=0, and no pop being accepted on the same edge. Pop has priority when both are eligible; the push stays pending until a later ACK.
- Write path: IDLE → W_SETUP → W_STROBE → W_HOLD → IDLE.
  - On the accept edge, latch RAM_ADDR = COUNT[AW-1:0] and RAM_DI = DIN.
  - W_SETUP: RAM_RWS=1, RAM_CS=0.
  - W_STROBE: RAM_RWS=1, RAM_CS=1.
  - W_HOLD: RAM_RWS=1, RAM_CS=0.
  - COUNT increments on the edge leaving W_STROBE.
- Read path: IDLE → R_SETUP → R_STROBE → IDLE.
  - On the accept edge, latch RAM_ADDR = COUNT-1. RAM_RWS=0 throughout.
  - RAM_CS=1 only in R_STROBE.
  - The edge leaving R_STROBE loads DOUT from RAM_DO, decrements COUNT and raises VALID.
- Error flags:
  - PUSH high in IDLE with FULL=1 (and no pop accepted): sets OVF, no ACK, no RAM access.
  - POP high in IDLE with EMPTY=1: sets UNF, no ACK.
  - OVF and UNF clear only on CLR or reset.
- CLR, in any state, on the next edge:
  - state → IDLE, COUNT → 0, OVF and UNF → 0, RAM_CS → 0.
  - No ACK or VALID is generated for that edge.
  - An aborted write leaves that RAM word undefined; it is above the new stack top, so this is harmless.
- Outputs in IDLE: RAM_CS=0, RAM_RWS=0, RAM_ADDR and RAM_DI hold their last values.
- Arithmetic: COUNT is AW+1 bits and never wraps. Push at COUNT = 2^AW-1 writes address 2^AW-1 and yields FULL.

## Timing
- Reset (asynchronous, RST_N low):
  - state IDLE, COUNT=0, EMPTY=1, FULL=0.
  - DOUT=0, VALID=0, ACK=0, BUSY=0, OVF=0, UNF=0.
  - RAM_CS=0, RAM_RWS=0, RAM_ADDR=0, RAM_DI=0.
  - Reset mid-access aborts it immediately: RAM_CS drops asynchronously.
- Push accepted at edge n:
  - ACK=1 and BUSY=1 in cycle n+1 (W_SETUP).
  - Strobe in n+2.
  - Updated COUNT/FULL/EMPTY visible in n+3 (W_HOLD).
  - IDLE in n+4; earliest next accept is edge n+4.
  - Throughput: 1 push per 4 cycles.
- Pop accepted at edge n:
  - ACK=1 in n+1 (R_SETUP).
  - Strobe in n+2.
  - DOUT valid, VALID=1 and COUNT decremented in n+3 (IDLE).
  - Next accept at edge n+3; throughput 1 pop per 3 cycles.
- All outputs are registered, with no combinational input-to-output paths.

## Structure
- Shared package stack_pkg holds:
  - AW/DW defaults.
  - State encoding localparams (3-bit: IDLE=0, W_SETUP=1, W_STROBE=2, W_HOLD=3, R_SETUP=4, R_STROBE=5).
  - DEPTH = 2^AW.
- One natural sub-module, stack_ptr: the AW+1-bit up/down/clear occupancy counter. It outputs COUNT, FULL, EMPTY and the push/pop addresses.
- The FSM and RAM port registers live in stack_ctrl. The RAM is instantiated one level up, alongside stack_ctrl.

## Test plan
- Reset, then push 0xA5:
  - ACK one cycle after the accept edge.
  - RAM_CS high for exactly 1 cycle with RAM_ADDR=0, RAM_DI=0xA5, RAM_RWS=1.
  - COUNT=1, EMPTY=0.
- Push 0x11, 0x22, 0x33, then pop three times:
  - DOUT reads 0x33, 0x22, 0x11 with one VALID pulse each.
  - COUNT ends at 0, EMPTY=1.
- Push 1024 words (data = addr[7:0]):
  - FULL=1, COUNT=1024.
  - A 1025th push sets OVF, gives no ACK and no RAM_CS.
  - Popping one word returns 0xFF and clears FULL.
- POP while empty: UNF=1, no ACK, no RAM_CS. A following CLR clears UNF.
- PUSH and POP held together with COUNT=2 (top 0x22):
  - The pop is acked first and DOUT=0x22.
  - The push is acked next and writes address 1.
- CLR asserted in W_STROBE: next cycle IDLE, RAM_CS=0, COUNT=0, no ACK or VALID.
- RST_N low mid-pop: RAM_CS drops asynchronously, and all outputs take their reset values without waiting for CLK.

Source files
------------

// File: rtl/stack_pkg.sv
// stack_pkg: shared widths, depth and FSM state encoding for the LIFO stack controller
package stack_pkg;
  localparam int STACK_AW = 10;
  localparam int STACK_DW = 8;
  localparam int STACK_DEPTH = 1 << STACK_AW;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_SETUP  = 3'd1,
    W_STROBE = 3'd2,
    W_HOLD   = 3'd3,
    R_SETUP  = 3'd4,
    R_STROBE = 3'd5
  } state_t;
endpackage

// File: rtl/stack_ptr.sv
// stack_ptr: AW+1-bit occupancy counter with full/empty flags and push/pop addresses
module stack_ptr
  import stack_pkg::*;
#(
  parameter int AW = STACK_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc_i,
  input  logic          dec_i,
  input  logic          clr_i,
  output logic [AW:0]   count_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW-1:0] push_addr_o,
  output logic [AW-1:0] pop_addr_o
);
  logic [AW:0] count_q, count_d;
  always_comb begin
    count_d = clr_i               ? '0 :
              (inc_i && !full_o)  ? count_q + 1'b1 :
              (dec_i && !empty_o) ? count_q - 1'b1 : count_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  // The counter never exceeds 2^AW, so the MSB alone means full.
  assign full_o      = count_q[AW];
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;
  assign push_addr_o = count_q[AW-1:0];
  assign pop_addr_o  = count_q[AW-1:0] - 1'b1;
endmodule

// File: rtl/stack_ctrl.sv
// stack_ctrl: sequences a single-port RAM as a LIFO with setup/strobe/hold accesses
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int AW = STACK_AW,
  parameter int DW = STACK_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          clr_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o,
  output logic          valid_o,
  output logic          ack_o,
  output logic          busy_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o,
  output logic          ovf_o,
  output logic          unf_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_di_o,
  input  logic [DW-1:0] ram_do_i,
  output logic          ram_cs_o,
  output logic          ram_rws_o
);
  state_t state_q;
  logic [AW-1:0] push_addr, pop_addr;
  logic pop_go, push_go, inc, dec;
  assign pop_go  = (state_q == IDLE) && !clr_i && pop_i && !empty_o;
  assign push_go = (state_q == IDLE) && !clr_i && push_i && !full_o && !pop_go;
  assign inc     = (state_q == W_STROBE) && !clr_i;
  assign dec     = (state_q == R_STROBE) && !clr_i;
  stack_ptr #(.AW(AW)) u_ptr (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_i      (inc),
    .dec_i      (dec),
    .clr_i      (clr_i),
    .count_o    (count_o),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .push_addr_o(push_addr),
    .pop_addr_o (pop_addr)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dout_o     <= '0;
      valid_o    <= 1'b0;
      ack_o      <= 1'b0;
      busy_o     <= 1'b0;
      ovf_o      <= 1'b0;
      unf_o      <= 1'b0;
      ram_addr_o <= '0;
      ram_di_o   <= '0;
      ram_cs_o   <= 1'b0;
      ram_rws_o  <= 1'b0;
    end else begin
      ack_o   <= 1'b0;
      valid_o <= 1'b0;
      if (clr_i) begin
        state_q   <= IDLE;
        busy_o    <= 1'b0;
        ovf_o     <= 1'b0;
        unf_o     <= 1'b0;
        ram_cs_o  <= 1'b0;
        ram_rws_o <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (pop_go) begin
              state_q    <= R_SETUP;
              ram_addr_o <= pop_addr;
              ram_rws_o  <= 1'b0;
              ack_o      <= 1'b1;
              busy_o     <= 1'b1;
            end else if (push_go) begin
              state_q    <= W_SETUP;
              ram_addr_o <= push_addr;
              ram_di_o   <= din_i;
              ram_rws_o  <= 1'b1;
              ack_o      <= 1'b1;
              busy_o     <= 1'b1;
            end
            if (push_i && full_o && !pop_go) ovf_o <= 1'b1;
            if (pop_i && empty_o) unf_o <= 1'b1;
          end
          W_SETUP: begin
            state_q  <= W_STROBE;
            ram_cs_o <= 1'b1;
          end
          W_STROBE: begin
            state_q  <= W_HOLD;
            ram_cs_o <= 1'b0;
          end
          W_HOLD: begin
            state_q   <= IDLE;
            ram_rws_o <= 1'b0;
            busy_o    <= 1'b0;
          end
          R_SETUP: begin
            state_q  <= R_STROBE;
            ram_cs_o <= 1'b1;
          end
          R_STROBE: begin
            state_q  <= IDLE;
            ram_cs_o <= 1'b0;
            dout_o   <= ram_do_i;
            valid_o  <= 1'b1;
            busy_o   <= 1'b0;
          end
          default: begin
            state_q   <= IDLE;
            ram_cs_o  <= 1'b0;
            ram_rws_o <= 1'b0;
            busy_o    <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule
